// File: rtl/blend_scheduler.sv
// blend_scheduler: read-modify-write scheduler between the rasterizer pixel stream and the alpha
// blender. It issues at most one pixel per cycle and stalls requests whose address is still being
// read-modify-written. Fully transparent pixels are consumed without an issue. End-of-frame is
// forwarded only after every in-flight pixel has been written back.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_pixel, in_r/g/b/a carry the request
//   mem_grant             framebuffer port available for new issues this cycle
//   frame_ready           single-cycle end-of-frame pulse from upstream
//   pixel_ready           issue strobe to the blender; pixel_number, r/g/b/a hold the issued pixel
//   o_frame_ready         single-cycle pulse once the frame is fully written
//   busy                  a pixel is in flight, or the scheduler is draining or finishing a frame
module blend_scheduler #(
  parameter int unsigned CLKWAIT = 2,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pixel,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  input  logic [7:0]        in_a,
  input  logic              mem_grant,
  input  logic              frame_ready,
  output logic              pixel_ready,
  output logic [ADDR_W-1:0] pixel_number,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic [7:0]        a,
  output logic              o_frame_ready,
  output logic              busy
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0] state_q, state_d;

  // Tracker: entry 0 is the issue register, entries 1..CLKWAIT follow it one per cycle so the
  // last entry lines up with the blender's write-back cycle.
  logic [CLKWAIT:0] vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [CLKWAIT+1];
  logic [ADDR_W-1:0] addr_d [CLKWAIT+1];

  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d, a_q, a_d;

  logic hazard;
  logic accept;
  logic issue;
  logic remain;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k <= CLKWAIT; k++) begin
      if (vld_q[k] && (addr_q[k] == in_pixel)) hazard = 1'b1;
    end
  end

  // Transparent pixels need no framebuffer access, so they bypass the grant but not the hazard
  // check (a later opaque write to the same pixel must not overtake an earlier one).
  assign in_ready = reset && (state_q == StRun) && !hazard && (mem_grant || (in_a == 8'd0));
  assign accept   = in_valid && in_ready;
  assign issue    = accept && (in_a != 8'd0);

  // Entries still valid after this cycle; in DRAIN nothing new is issued.
  assign remain = |vld_q[CLKWAIT-1:0];

  always_comb begin
    vld_d     = {vld_q[CLKWAIT-1:0], issue};
    addr_d[0] = issue ? in_pixel : addr_q[0];
    for (int unsigned k = 1; k <= CLKWAIT; k++) begin
      addr_d[k] = addr_q[k-1];
    end
    r_d = issue ? in_r : r_q;
    g_d = issue ? in_g : g_q;
    b_d = issue ? in_b : b_q;
    a_d = issue ? in_a : a_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (frame_ready) state_d = StDrain;
      StDrain: if (!remain) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      vld_q   <= '0;
      for (int unsigned k = 0; k <= CLKWAIT; k++) begin
        addr_q[k] <= '0;
      end
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      a_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      for (int unsigned k = 0; k <= CLKWAIT; k++) begin
        addr_q[k] <= addr_d[k];
      end
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      a_q <= a_d;
    end
  end

  assign pixel_ready   = vld_q[0];
  assign pixel_number  = addr_q[0];
  assign r             = r_q;
  assign g             = g_q;
  assign b             = b_q;
  assign a             = a_q;
  assign o_frame_ready = (state_q == StDone);
  assign busy          = (|vld_q) || (state_q != StRun);

endmodule

// File: tb/tb_blend_scheduler.sv
// Self-checking bench for blend_scheduler: directed scenarios plus randomized traffic, compared
// cycle by cycle against a timeline model of in-flight pixels and frame drains.
module tb_blend_scheduler;

  localparam int CLKWAIT = 2;
  localparam int ADDR_W  = 19;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pixel;
  logic [7:0]        in_r, in_g, in_b, in_a;
  logic              mem_grant;
  logic              frame_ready;
  logic              pixel_ready;
  logic [ADDR_W-1:0] pixel_number;
  logic [7:0]        r, g, b, a;
  logic              o_frame_ready;
  logic              busy;

  always #5 clk = ~clk;

  blend_scheduler #(
    .CLKWAIT(CLKWAIT),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .in_r         (in_r),
    .in_g         (in_g),
    .in_b         (in_b),
    .in_a         (in_a),
    .mem_grant    (mem_grant),
    .frame_ready  (frame_ready),
    .pixel_ready  (pixel_ready),
    .pixel_number (pixel_number),
    .r            (r),
    .g            (g),
    .b            (b),
    .a            (a),
    .o_frame_ready(o_frame_ready),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: issued pixels as (address, accept cycle); a pixel accepted at t occupies the
  // framebuffer path during cycles t+1 .. t+1+CLKWAIT.
  int q_addr[$];
  int q_t[$];
  int frame_f = 0;
  int done_at = -1;   // cycle of o_frame_ready, -1 when no frame is being finished
  int last_issue = -100;
  int e_pn = 0, e_r = 0, e_g = 0, e_b = 0, e_a = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_run();
    return (done_at < 0) || (cyc <= frame_f);
  endfunction

  function automatic bit in_flight(input int p);
    foreach (q_addr[i]) if (q_addr[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q_addr.delete();
    q_t.delete();
    done_at = -1;
    last_issue = -100;
    e_pn = 0; e_r = 0; e_g = 0; e_b = 0; e_a = 0;
  endtask

  task automatic drive_cycle(input bit v, input int p, input int rv, input int gv, input int bv,
                             input int av, input bit grant, input bit fr);
    bit exp_rdy, acc;
    int last_w;
    @(negedge clk);
    in_valid = v; in_pixel = p[ADDR_W-1:0];
    in_r = rv[7:0]; in_g = gv[7:0]; in_b = bv[7:0]; in_a = av[7:0];
    mem_grant = grant; frame_ready = fr;
    #1;
    if (done_at >= 0 && cyc > done_at) done_at = -1;
    while (q_t.size() > 0 && q_t[0] + 1 + CLKWAIT < cyc) begin
      void'(q_t.pop_front());
      void'(q_addr.pop_front());
    end
    exp_rdy = reset && in_run() && !in_flight(p) && (grant || av == 0);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("pixel_ready", 32'(pixel_ready), 32'(last_issue == cyc - 1));
    check_eq("pixel_number", 32'(pixel_number), e_pn);
    check_eq("r", 32'(r), e_r);
    check_eq("g", 32'(g), e_g);
    check_eq("b", 32'(b), e_b);
    check_eq("a", 32'(a), e_a);
    check_eq("o_frame_ready", 32'(o_frame_ready), 32'(done_at >= 0 && cyc == done_at));
    check_eq("busy", 32'(busy), 32'(q_t.size() > 0 || !in_run()));
    acc = v && exp_rdy;
    if (acc && av != 0) begin
      q_addr.push_back(p);
      q_t.push_back(cyc);
      last_issue = cyc;
      e_pn = p; e_r = rv; e_g = gv; e_b = bv; e_a = av;
    end
    if (reset && fr && done_at < 0) begin
      last_w = -100;
      foreach (q_t[i]) if (q_t[i] + 1 + CLKWAIT > last_w) last_w = q_t[i] + 1 + CLKWAIT;
      frame_f = cyc;
      done_at = (cyc + 2 > last_w + 1) ? cyc + 2 : last_w + 1;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_pixel_ready"}, 32'(pixel_ready), 32'd0);
    check_eq({tag, "_pixel_number"}, 32'(pixel_number), 32'd0);
    check_eq({tag, "_rgba"}, {r, g, b, a}, 32'd0);
    check_eq({tag, "_o_frame_ready"}, 32'(o_frame_ready), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int p, av;
    reset = 1'b0;
    in_valid = 1'b1; in_pixel = '0; in_r = 8'd1; in_g = 8'd2; in_b = 8'd3; in_a = 8'd5;
    mem_grant = 1'b1; frame_ready = 1'b0;
    #3;
    check_all_zero("reset");
    idle(2);
    #1 reset = 1'b1;
    idle(2);

    // Single pixel.
    drive_cycle(1'b1, 100, 200, 0, 0, 128, 1'b1, 1'b0);
    idle(5);

    // Back-to-back distinct addresses.
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, i, i * 3, i * 5, i * 7, i + 1, 1'b1, 1'b0);
    idle(5);

    // Same-address hazard, held until accepted.
    drive_cycle(1'b1, 5, 1, 2, 3, 4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 5, 9, 9, 9, 9, 1'b1, 1'b0);
    drive_cycle(1'b1, 5, 1, 2, 3, 4, 1'b1, 1'b0);
    drive_cycle(1'b1, 6, 7, 7, 7, 7, 1'b1, 1'b0);
    // Addresses differing only in the top bit must not collide.
    drive_cycle(1'b1, 6 | (1 << 18), 8, 8, 8, 8, 1'b1, 1'b0);
    idle(5);

    // Transparent pixel without grant, then opaque one waiting for grant.
    drive_cycle(1'b1, 40, 1, 1, 1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 40, 1, 1, 1, 1, 1'b0, 1'b0);
    drive_cycle(1'b1, 40, 1, 1, 1, 1, 1'b1, 1'b0);
    idle(5);

    // Frame drain with a duplicate frame pulse during DRAIN.
    drive_cycle(1'b1, 50, 10, 20, 30, 40, 1'b1, 1'b0);
    drive_cycle(1'b1, 51, 11, 21, 31, 41, 1'b1, 1'b1);
    drive_cycle(1'b1, 52, 12, 22, 32, 42, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 53, 1, 1, 1, 1, 1'b1, 1'b0);
    // Frame with nothing in flight.
    idle(4);
    drive_cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    idle(5);

    // Reset while draining with three pixels in flight.
    drive_cycle(1'b1, 60, 1, 2, 3, 4, 1'b1, 1'b0);
    drive_cycle(1'b1, 61, 1, 2, 3, 4, 1'b1, 1'b0);
    drive_cycle(1'b1, 62, 1, 2, 3, 4, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd9; mem_grant = 1'b1; frame_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    model_reset();
    @(posedge clk);
    cyc++;
    idle(1);
    #1 reset = 1'b1;
    drive_cycle(1'b1, 60, 5, 5, 5, 5, 1'b1, 1'b0);
    idle(6);

    // Randomized traffic with small address sets to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      p  = $urandom_range(0, 7) | (($urandom_range(0, 3) == 0) ? (1 << 18) : 0);
      av = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      drive_cycle($urandom_range(0, 4) != 0, p, $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), av, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/blend_scheduler.md
# blend_scheduler

Read-modify-write scheduler that sits between the rasterizer pixel stream and the alpha blender. It accepts RGBA pixel requests over a valid/ready handshake and issues them to the blender one per cycle. It tracks every pixel whose framebuffer read has been issued but whose write-back has not yet completed, and stalls any request that targets a pixel already in flight. It discards fully transparent pixels, yields to the framebuffer port owner, and drains the pipeline before forwarding the end-of-frame indication.

## Interface
- CLKWAIT, 2: read-to-write latency of the blender, in cycles; must be ≥1 and equal to the blender's setting.
- ADDR_W, 19: pixel address width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel request valid.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- in_pixel  in  ADDR_W  target pixel number.
- in_r, in_g, in_b, in_a  in  8 each  source color and alpha.
- mem_grant  in  1  framebuffer port available to blending this cycle.
- frame_ready  in  1  single-cycle end-of-frame pulse from upstream.
- pixel_ready  out  1  issue strobe to the blender (framebuffer read).
- pixel_number  out  ADDR_W  issued address.
- r, g, b, a  out  8 each  issued source color and alpha.
- o_frame_ready  out  1  single-cycle pulse, frame fully written.
- busy  out  1  any pixel in flight, or state ≠ RUN.

## Operation
- In-flight tracker: CLKWAIT+1 entries, each holding a valid bit and an address.
  - Entry 0 is the issue register.
  - Entries 1..CLKWAIT form a shift chain, so the entry in the last position corresponds to the blender's write cycle.
  - Each entry shifts every cycle and loses its valid bit when it leaves the chain.
- Hazard: in_pixel equals the address of any valid tracker entry, with a combinational compare.
- in_ready = (state == RUN) && !hazard && (mem_grant || in_a == 0).
- Accept with in_a != 0: load the issue register; on the next cycle pixel_ready = 1 and pixel_number, r, g, b, a show the accepted values.
- Accept with in_a == 0: consume the request and issue nothing, because the destination pixel is unchanged. The hazard check still applies, to preserve ordering.
- With no accept in a cycle: pixel_ready = 0 on the next cycle. Data outputs hold their last values.
- FSM:
  - RUN: normal operation. On a frame_ready pulse go to DRAIN. A pixel accepted in the same cycle as frame_ready is issued before the drain begins.
  - DRAIN: in_ready = 0. Go to DONE when no tracker entry is valid.
  - DONE: o_frame_ready = 1 for exactly this one cycle, then go to RUN.
- frame_ready pulses arriving in DRAIN or DONE are ignored.
- Addresses are compared over the full ADDR_W bits. There is no wrap or truncation.

## Timing
- Reset (asynchronous, reset low) sets:
  - all tracker valid bits to 0 and state to RUN;
  - pixel_ready, o_frame_ready, and busy to 0;
  - pixel_number, r, g, b, a to 0.
- in_ready is 0 while reset is asserted.
- Latency:
  - A request accepted in cycle t gives pixel_ready in cycle t+1.
  - The blender writes in cycle t+1+CLKWAIT.
- Same-address stall: a second request to a pixel accepted in cycle t is accepted no earlier than cycle t+2+CLKWAIT, i.e. t+4 at the default.
- Throughput: one request per cycle for distinct addresses while mem_grant = 1.
- mem_grant = 0 blocks only the issue of new pixels. Pixels already in flight complete unaffected.
- Drain: o_frame_ready asserts in the cycle after the last in-flight entry expires. If nothing is in flight, it asserts 2 cycles after the frame_ready pulse.
- Reset mid-operation discards all in-flight tracking. Partially blended pixels are not recovered.

## Test plan
- Single pixel: P=100, rgba=(200,0,0,128), grant=1, accepted at t=0 → pixel_ready=1 at t=1 only, pixel_number=100, a=128; busy=1 from t=1 through t=3.
- Back-to-back distinct addresses 0..7 with grant=1 → in_ready stays 1, and pixel_ready is 1 for 8 consecutive cycles in order.
- Hazard: P=5 accepted at t=0, P=5 presented at t=1 → in_ready=0 for t=1..3, accepted at t=4; P=6 presented instead → accepted at t=1.
- Transparent pixel: a=0 with mem_grant=0 → accepted immediately, pixel_ready stays 0. Same pixel with a=1 and mem_grant=0 → in_ready=0 until grant returns.
- Frame drain: frame_ready pulses in the same cycle as the acceptance of the last pixel → in_ready=0 during DRAIN; o_frame_ready pulses exactly once, CLKWAIT+2 cycles after that acceptance; a second frame_ready during DRAIN produces no extra pulse.
- Reset mid-operation: assert reset with 3 pixels in flight and state DRAIN → all outputs 0 immediately; after release, state RUN, in_ready=1, and no spurious o_frame_ready.
